// File: rtl/spi_cs_arbiter.sv
// Round-robin arbiter sharing one SPI host among NumReq chip-select owners, with CS setup/idle
// sequencing. Optional inactivity timeout enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_cs_arbiter #(
    parameter int unsigned NumReq        = 4,
    parameter int unsigned CsSetupCycles = 2,
    parameter int unsigned CsIdleCycles  = 3,
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic                      clk_sys_i,
    input  logic                      rst_sys_i,
    input  logic [NumReq-1:0]         req_i,
    input  logic [NumReq-1:0]         release_i,
    input  logic                      activity_i,
    output logic [NumReq-1:0]         gnt_o,
    output logic [$clog2(NumReq)-1:0] owner_o,
    output logic                      busy_o,
    output logic [NumReq-1:0]         spi_cs_no,
    output logic                      timeout_o
);

    localparam int unsigned IdxW   = $clog2(NumReq);
    localparam int unsigned CntMax = (CsSetupCycles > CsIdleCycles) ? CsSetupCycles
                                                                     : CsIdleCycles;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam logic [NumReq-1:0] Lsb = NumReq'(1);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StOwned,
        StTeardown
    } state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [IdxW-1:0]   rr_q;

    logic              any_req;
    logic [IdxW-1:0]   winner;
    logic [IdxW-1:0]   cand;
    logic [IdxW-1:0]   rr_after_owner;
    logic [NumReq-1:0] owner_onehot;
    logic [NumReq-1:0] winner_onehot;
    logic              owner_req;
    logic              owner_rel;
    logic              enter_owned;
    logic              tmo_fire;
    logic              tmo_expired;

    // First set request searching upward from rr_q, wrapping at NumReq.
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        cand    = '0;
        for (int k = 0; k < NumReq; k++) begin
            cand = IdxW'((int'(rr_q) + k) % NumReq);
            if (!any_req && req_i[cand]) begin
                any_req = 1'b1;
                winner  = cand;
            end
        end
    end

    assign owner_onehot   = Lsb << owner_o;
    assign winner_onehot  = Lsb << winner;
    assign owner_req      = req_i[owner_o];
    assign owner_rel      = release_i[owner_o];
    assign rr_after_owner = (owner_o == IdxW'(NumReq - 1)) ? '0 : owner_o + IdxW'(1);
    assign enter_owned    = (state_q == StSetup) && owner_req && (cnt_q == '0);

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);

    logic [TmoW-1:0] tmo_q;

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            tmo_q <= '0;
        end else if (enter_owned || activity_i) begin
            tmo_q <= TmoW'(TimeoutCycles);
        end else if (tmo_q != '0) begin
            tmo_q <= tmo_q - TmoW'(1);
        end
    end

    // The pulse is issued as the count reaches zero; revocation follows on the next edge.
    assign tmo_fire    = (state_q == StOwned) && (tmo_q == TmoW'(1)) && !activity_i;
    assign tmo_expired = (state_q == StOwned) && (tmo_q == '0);
`else
    logic unused_activity;
    assign unused_activity = activity_i ^ (TimeoutCycles == 0);
    assign tmo_fire        = 1'b0;
    assign tmo_expired     = 1'b0;
`endif

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            rr_q      <= '0;
            gnt_o     <= '0;
            owner_o   <= '0;
            busy_o    <= 1'b0;
            spi_cs_no <= '1;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        state_q   <= StSetup;
                        owner_o   <= winner;
                        spi_cs_no <= ~winner_onehot;
                        busy_o    <= 1'b1;
                        cnt_q     <= CntW'(CsSetupCycles - 1);
                    end
                end
                StSetup: begin
                    if (!owner_req) begin
                        state_q   <= StTeardown;
                        spi_cs_no <= '1;
                        cnt_q     <= CntW'(CsIdleCycles - 1);
                        rr_q      <= rr_after_owner;
                    end else if (cnt_q == '0) begin
                        state_q <= StOwned;
                        gnt_o   <= owner_onehot;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StOwned: begin
                    // Release beats a still-asserted request, so the owner drops to lowest priority.
                    if (owner_rel || !owner_req || tmo_expired) begin
                        state_q   <= StTeardown;
                        gnt_o     <= '0;
                        spi_cs_no <= '1;
                        cnt_q     <= CntW'(CsIdleCycles - 1);
                        rr_q      <= rr_after_owner;
                    end else if (tmo_fire) begin
                        timeout_o <= 1'b1;
                    end
                end
                StTeardown: begin
                    if (cnt_q == '0) begin
                        state_q <= StIdle;
                        busy_o  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    gnt_onehot_a: assert property (@(posedge clk_sys_i) disable iff (rst_sys_i)
        $onehot0(gnt_o));
    cs_onehot_a: assert property (@(posedge clk_sys_i) disable iff (rst_sys_i)
        $onehot0(~spi_cs_no));
    gnt_has_cs_a: assert property (@(posedge clk_sys_i) disable iff (rst_sys_i)
        (gnt_o & spi_cs_no) == '0);

endmodule
